// File: rtl/data_sram_responder.sv
// data_sram_responder: fixed-latency word SRAM slave with byte-strobed writes.
// One request is in flight at a time; a new one may be accepted in its data_ok cycle.
module data_sram_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] BUSY     = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  data_ok_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  unused_addr;

    assign idx               = data_sram_addr[DEPTH_LOG2+1:2];
    assign unused_addr       = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};
    assign data_sram_addr_ok = state_q == IDLE || cnt_q == 4'd0;
    assign accept            = data_sram_req && data_sram_addr_ok;
    assign data_sram_data_ok = data_ok_q;
    assign data_sram_rdata   = rdata_q;

    always_comb begin
        state_d = (accept || (state_q == BUSY && cnt_q != 4'd0)) ? BUSY : IDLE;
        cnt_d   = accept ? CNT_LOAD : (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
    end

    // data_ok is registered from the next state so it rises exactly in the cnt==0 BUSY cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_ok_q <= state_d == BUSY && cnt_d == 4'd0;
            if (accept)
                rdata_q <= data_sram_wr ? 32'h0 : mem_q[idx];
        end
    end

    // Array is never reset so committed writes survive resetn
    always_ff @(posedge clk) begin
        if (accept && resetn && data_sram_wr)
            for (int b = 0; b < 4; b++)
                if (data_sram_wstrb[b])
                    mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: LATENCY=1 and LATENCY=3 instances checked every cycle
// against a transaction-level model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_data_sram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn, req, wr, aok, dok;
    logic [1:0][3:0]  strb;
    logic [1:0][31:0] addr, wdata, rdata;
    int checks = 0, failures = 0, cyc = 0;

    logic [31:0] mm [2][1024];
    logic [1:0]  rv, acc;
    int          due [2];
    logic [31:0] erd [2];
    logic        eaok, edok;
    logic [63:0] lg0 [$];
    logic [63:0] lg1 [$];

    data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u0 (
        .clk(clk), .resetn(rstn[0]), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
        .data_sram_wstrb(strb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
        .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]), .data_sram_rdata(rdata[0]));
    data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u1 (
        .clk(clk), .resetn(rstn[1]), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
        .data_sram_wstrb(strb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
        .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]), .data_sram_rdata(rdata[1]));

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: one outstanding response due LATENCY cycles after its accept cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstn[k]) begin
                chk($sformatf("rst_aok%0d", k), 32'(aok[k]), 32'd1);
                chk($sformatf("rst_dok%0d", k), 32'(dok[k]), 32'd0);
                chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
                rv[k] = 1'b0; acc[k] = 1'b0; erd[k] = 32'h0;
            end else begin
                eaok = !rv[k] || due[k] <= cyc;
                edok = rv[k] && due[k] == cyc;
                chk($sformatf("aok%0d", k), 32'(aok[k]), 32'(eaok));
                chk($sformatf("dok%0d", k), 32'(dok[k]), 32'(edok));
                chk($sformatf("rdata%0d", k), rdata[k], erd[k]);
                if (dok[k]) begin
                    if (k == 0) lg0.push_back({32'(cyc), rdata[k]});
                    else        lg1.push_back({32'(cyc), rdata[k]});
                end
                if (edok) rv[k] = 1'b0;
                acc[k] = req[k] && eaok;
                if (acc[k]) begin
                    erd[k] = wr[k] ? 32'h0 : mm[k][addr[k][11:2]];
                    if (wr[k])
                        for (int b = 0; b < 4; b++)
                            if (strb[k][b]) mm[k][addr[k][11:2]][8*b +: 8] = wdata[k][8*b +: 8];
                    rv[k] = 1'b1;
                    due[k] = cyc + (k == 0 ? 1 : 3);
                end
            end
        end
    end

    task automatic issue(int k, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        req[k] = 1'b1; wr[k] = w; strb[k] = s; addr[k] = a; wdata[k] = d;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (acc[k]) begin
                #2;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL accept_timeout inst=%0d act=no_accept exp=accept", k);
        #2;
    endtask

    task automatic idle(int k, int n);
        req[k] = 1'b0;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rst(int k, int n);
        req[k] = 1'b0; rstn[k] = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rstn[k] = 1'b1;
    endtask

    initial begin
        rstn = 2'b00; req = 2'b00; wr = 2'b00; strb = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 2'b11;
        // LATENCY=1: write then read back-to-back
        issue(0, 1, 4'hF, 32'h10, 32'h12345678);
        issue(0, 0, 4'h0, 32'h10, 32'h0);
        idle(0, 4);
        chk("d034_n", lg0.size(), 2);
        chk("d034_wr_rdata", lg0[0][31:0], 32'h0);
        chk("d034_rd_rdata", lg0[1][31:0], 32'h12345678);
        chk("d034_gap", lg0[1][63:32] - lg0[0][63:32], 1);
        lg0.delete();
        issue(0, 1, 4'b0100, 32'h10, 32'hAABBCCDD);
        issue(0, 0, 4'h0, 32'h10, 32'h0);
        idle(0, 4);
        chk("d035_partial", lg0[1][31:0], 32'h12BB5678);
        lg0.delete();
        for (int i = 0; i < 3; i++) issue(0, 1, 4'hF, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 3; i++) issue(0, 0, 4'h0, 32'(4 * i), 32'h0);
        idle(0, 4);
        chk("d037_n", lg0.size(), 6);
        chk("d037_r1", lg0[3][31:0], 32'd1);
        chk("d037_r2", lg0[4][31:0], 32'd2);
        chk("d037_r3", lg0[5][31:0], 32'd3);
        chk("d037_consec", lg0[5][63:32] - lg0[3][63:32], 2);
        lg0.delete();
        issue(0, 1, 4'hF, 32'h1004, 32'hCAFEF00D);
        issue(0, 0, 4'h0, 32'h0004, 32'h0);
        idle(0, 4);
        chk("d038_alias", lg0[1][31:0], 32'hCAFEF00D);
        // LATENCY=3: held request accepted in the data_ok cycle
        issue(1, 1, 4'hF, 32'h10, 32'h5A5A1234);
        lg1.delete();
        idle(1, 4);
        issue(1, 0, 4'h0, 32'h10, 32'h0);
        req[1] = 1'b1;
        chk("d036_aok_busy", 32'(aok[1]), 32'd0);
        issue(1, 0, 4'h0, 32'h10, 32'h0);
        idle(1, 8);
        chk("d036_n", lg1.size(), 3);
        chk("d036_rdata", lg1[1][31:0], 32'h5A5A1234);
        chk("d036_gap", lg1[2][63:32] - lg1[1][63:32], 3);
        // Reset during BUSY drops the response but keeps the committed write
        issue(1, 1, 4'hF, 32'h20, 32'h22222222);
        idle(1, 4);
        issue(1, 1, 4'hF, 32'h20, 32'h11111111);
        lg1.delete();
        rst(1, 3);
        idle(1, 5);
        chk("d038_no_dok", lg1.size(), 0);
        issue(1, 0, 4'h0, 32'h20, 32'h0);
        idle(1, 6);
        chk("d038_persist", lg1[0][31:0], 32'h11111111);
        // Randomized traffic with aliasing addresses and mid-traffic resets
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) issue(k, 1, 4'hF, ($urandom & 32'hFFFFF000) | 32'(4 * i), $urandom);
            for (int n = 0; n < 250; n++) begin
                issue(k, 1'($urandom_range(0, 1)), 4'($urandom),
                      ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3)),
                      $urandom);
                if ($urandom_range(0, 39) == 0) rst(k, 3);
                else if ($urandom_range(0, 3) == 0) idle(k, $urandom_range(0, 3));
            end
            idle(k, 6);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 32-bit words in the array.
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_sram_req  input  1  request valid from the pipeline.
REQ-006 data_sram_wr  input  1  1 = write, 0 = read.
REQ-007 data_sram_wstrb  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-008 data_sram_addr  input  32  byte address.
REQ-009 data_sram_wdata  input  32  write data.
REQ-010 data_sram_addr_ok  output  1  request accepted this cycle when high together with data_sram_req.
REQ-011 data_sram_data_ok  output  1  one-cycle response strobe.
REQ-012 data_sram_rdata  output  32  read data, valid while data_sram_data_ok is high.

Function
REQ-013 The array SHALL hold 2^DEPTH_LOG2 words, indexed by addr[DEPTH_LOG2+1:2]; addr[1:0] and bits above DEPTH_LOG2+1 SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2.
REQ-014 The FSM SHALL have two states: IDLE and BUSY, with a 4-bit down-counter cnt.
REQ-015 data_sram_addr_ok SHALL be combinational: high in IDLE, high in BUSY when cnt==0, low otherwise.
REQ-016 Accept = data_sram_req && data_sram_addr_ok at a rising edge; wr, wstrb, addr and wdata SHALL be sampled only at accept.
REQ-017 data_sram_req without addr_ok SHALL have no effect; the requester holds the request until accepted.
REQ-018 On accept the FSM SHALL enter or stay in BUSY with cnt loaded to LATENCY-1.
REQ-019 In BUSY with cnt!=0, each edge SHALL decrement cnt.
REQ-020 In BUSY with cnt==0 and no accept, the next edge SHALL return the FSM to IDLE.
REQ-021 data_sram_data_ok SHALL be registered and high exactly when state==BUSY and cnt==0, for one cycle per accepted request.
REQ-022 Response latency SHALL be LATENCY cycles: if accept occurs in cycle c, data_ok is high in cycle c+LATENCY.
REQ-023 A new accept in the data_ok cycle SHALL be allowed, giving one request per cycle at LATENCY=1 and one per LATENCY cycles otherwise.
REQ-024 Write commit: at the accept edge of a write, each byte with wstrb[i]=1 SHALL be written and bytes with wstrb[i]=0 SHALL be unchanged; wstrb=0 writes nothing but still gets a response.
REQ-025 Read: at the accept edge of a read, the addressed word SHALL be captured into an rdata register, which drives data_sram_rdata and holds until the next accept.
REQ-026 For a write, the rdata register SHALL be loaded with 32'h0 at accept.
REQ-027 Ordering: a write committed at an earlier edge SHALL be visible to any later-accepted read; responses SHALL return in acceptance order.

Reset
REQ-028 While resetn is low: state=IDLE, cnt=0, data_sram_data_ok=0, data_sram_rdata=32'h0, data_sram_addr_ok=1.
REQ-029 Reset during BUSY SHALL drop the pending response, with no data_ok after deassertion.
REQ-030 Writes already committed SHALL persist through reset.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 Reset deassertion SHALL be usable at any edge; the first accept is allowed in the first cycle after release.

Verification
REQ-033 Reset: hold resetn=0 for 3 cycles mid-traffic -> addr_ok=1, data_ok=0, rdata=0 throughout.
REQ-034 LATENCY=1: write 0x12345678 wstrb=4'hF at addr 0x10 in cycle c, read 0x10 in cycle c+1 -> data_ok in c+1 (rdata 0) and in c+2 with rdata=0x12345678.
REQ-035 Partial write: wstrb=4'b0100, wdata=0xAABBCCDD onto word 0x12345678, then read -> 0x12BB5678.
REQ-036 LATENCY=3: read accepted in cycle c -> addr_ok low in c+1 and c+2; data_ok high only in c+3; addr_ok high in c+3; a request held from c+1 is accepted in c+3.
REQ-037 LATENCY=1: reads to 0x0,0x4,0x8 accepted back-to-back after writing 1,2,3 -> data_ok high for 3 consecutive cycles with rdata 1,2,3 in order.
REQ-038 DEPTH_LOG2=10: write 0xCAFEF00D to 0x1004, then read 0x0004 -> 0xCAFEF00D; reset asserted at cnt=2 of a LATENCY=3 write -> no data_ok, and a later read returns the new data.
